switch_event_scheduler: RTL and testbench
=========================================

# switch_event_scheduler

Collects one-shot switch events (one pulse per channel per change) from the four-channel switch one-shot stage, holds them as sticky pending requests and hands them one at a time to a single downstream consumer over a valid/ready handshake. Channels are served round-robin, with a programmable idle gap between deliveries. Events that arrive while a channel is still pending are merged and counted as overflows. The block sits between the switch front-end and any control FSM that must not miss a switch change.

## Interface
Parameters:
- HOLDOFF, 2, idle cycles forced after each accepted event before the next grant (0 allowed)
- CNT_W, 8, width of the saturating overflow counter

Ports:
- CLK50MHZ  in  1  system clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- ev_in  in  4  one-shot event pulses, bit i = channel i changed this cycle
- sw_level  in  4  current switch levels, sampled with ev_in
- ev_valid  out  1  event offered to consumer
- ev_ready  in  1  consumer accepts offered event
- ev_idx  out  2  channel of offered event
- ev_level  out  1  switch level captured with the offered event
- ev_pending  out  4  sticky pending flags per channel
- overflow_cnt  out  CNT_W  count of merged (lost) events, saturating

## Operation
- Reset values: ev_valid=0, ev_idx=0, ev_level=0, ev_pending=0, overflow_cnt=0, internal last_grant=3 (so channel 0 wins first), state=IDLE, gap counter=0.
- Capture: on each edge, for each i with ev_in[i]=1: pending[i]<=1, lvl_cap[i]<=sw_level[i].
- Overflow: if ev_in[i]=1 while pending[i]=1 and pending[i] is not being cleared this cycle, overflow_cnt increments by 1. Saturates at 2^CNT_W-1. Cleared only by RST. Multiple channels overflowing in the same cycle add 1, not N.
- FSM states: IDLE, OFFER, GAP.
- IDLE: if any pending bit is set, select the first set bit searching last_grant+1, +2, +3, +4 (mod 4). Then ev_idx<=sel, ev_level<=lvl_cap[sel], pending[sel]<=0, last_grant<=sel, ev_valid<=1, go to OFFER. If no pending bit is set, stay in IDLE.
- Grant/capture collision: if ev_in[sel]=1 in the grant cycle, the new capture wins. pending[sel] stays 1, lvl_cap[sel] takes the new level, ev_level takes the old lvl_cap. This is not an overflow.
- OFFER: ev_valid=1. ev_idx and ev_level are held stable until ev_valid&&ev_ready. On handshake: ev_valid<=0. Go to GAP with counter=HOLDOFF-1 if HOLDOFF>0, else go to IDLE.
- Events arriving during OFFER or GAP only set pending. They never alter the offered ev_idx or ev_level.
- GAP: the counter decrements each cycle. Go to IDLE when the counter reaches 0. ev_valid=0 throughout.
- RST asserted mid-offer drops ev_valid immediately (asynchronously) without a handshake. All pending events are discarded.

## Timing
- ev_in pulse at edge k sets pending at edge k. With the FSM in IDLE, the grant is registered at edge k+1, so ev_valid is high after edge k+1. Event-to-valid latency is 2 edges.
- ev_ready may be high before ev_valid. Acceptance occurs on the first edge with both high. The minimum OFFER duration is 1 cycle.
- Back-to-back throughput with ev_ready held high is one event per (2+HOLDOFF) cycles: 1 OFFER cycle, HOLDOFF GAP cycles, and 1 IDLE grant cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then a single pulse ev_in=4'b0100 with sw_level=4'b0100, ev_ready=1 -> ev_valid high 2 edges later with ev_idx=2, ev_level=1, held for 1 cycle. ev_pending returns to 0. overflow_cnt=0.
- ev_in=4'b1111 in one cycle, sw_level=4'b1010, ev_ready=1, HOLDOFF=2 -> deliveries in order idx 0,1,2,3 with levels 0,1,0,1. Consecutive ev_valid rising edges are 4 cycles apart.
- ev_ready=0 for 10 cycles while offering idx 1 -> ev_idx and ev_level remain stable. A second pulse on channel 1 during OFFER sets pending[1] with no overflow. After ready, channel 1 is delivered again with the new level.
- Three pulses on channel 3 while pending[3]=1 and the FSM is in OFFER on another channel -> overflow_cnt=3. A single delivery of channel 3 carries the last captured level. With CNT_W=2 and 5 overflows -> overflow_cnt=3 (saturated).
- Pulse on channel 0 exactly in the cycle channel 0 is granted -> the offered ev_level is the old level, pending[0]=1 afterwards, overflow_cnt unchanged.
- RST asserted mid-OFFER, asynchronously between clock edges -> ev_valid, ev_pending and overflow_cnt are 0 before the next edge. After release, the next grant picks channel 0 first.

Source files
------------

// File: rtl/switch_event_scheduler.sv
// Sticky per-channel event collector with round-robin delivery over valid/ready.
// A programmable idle gap separates consecutive deliveries; merged events are counted.
module switch_event_scheduler #(
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CLK50MHZ,
    input  logic             RST,
    input  logic [3:0]       ev_in,
    input  logic [3:0]       sw_level,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_idx,
    output logic             ev_level,
    output logic [3:0]       ev_pending,
    output logic [CNT_W-1:0] overflow_cnt
);

    localparam int unsigned GAP_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StOffer = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       lvl_q, lvl_d;
    logic [1:0]       last_q, last_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             valid_q, valid_d;
    logic [1:0]       idx_q, idx_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic [1:0] sel;
    logic       grant;
    logic       handshake;
    logic [3:0] clr;
    logic       ovf_hit;

    // Round-robin pick: scan from farthest to nearest so the nearest set bit wins.
    always_comb begin
        logic [1:0] cand;
        sel = last_q + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (pend_q[cand]) begin
                sel = cand;
            end
        end
    end

    assign grant     = (state_q == StIdle) && (|pend_q);
    assign handshake = (state_q == StOffer) && ev_ready;
    assign clr       = grant ? (4'b0001 << sel) : 4'b0000;
    // A fresh capture on the channel being granted is not a merge.
    assign ovf_hit   = |(ev_in & pend_q & ~clr);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        level_d = level_q;
        ovf_d   = ovf_q;

        pend_d = (pend_q & ~clr) | ev_in;
        lvl_d  = (lvl_q & ~ev_in) | (sw_level & ev_in);

        if (ovf_hit && (ovf_q != {CNT_W{1'b1}})) begin
            ovf_d = ovf_q + CNT_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (grant) begin
                    idx_d   = sel;
                    level_d = lvl_q[sel];
                    last_d  = sel;
                    valid_d = 1'b1;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (HOLDOFF > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            pend_q  <= 4'b0000;
            lvl_q   <= 4'b0000;
            last_q  <= 2'd3;
            gap_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= 2'd0;
            level_q <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            lvl_q   <= lvl_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ev_valid     = valid_q;
    assign ev_idx       = idx_q;
    assign ev_level     = level_q;
    assign ev_pending   = pend_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_switch_event_scheduler.sv
// Bench for switch_event_scheduler: two instances (HOLDOFF=2/CNT_W=8 and HOLDOFF=0/CNT_W=2)
// share stimulus and are compared every cycle against a cycle-count based reference model.
module tb_switch_event_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ev_in;
    logic [3:0] sw_level;
    logic       ev_ready;

    logic       valid0, valid1;
    logic [1:0] idx0, idx1;
    logic       level0, level1;
    logic [3:0] pend0, pend1;
    logic [7:0] ovf0;
    logic [1:0] ovf1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_event_scheduler #(.HOLDOFF(2), .CNT_W(8)) u_dut0 (
        .CLK50MHZ     (clk),
        .RST          (rst),
        .ev_in        (ev_in),
        .sw_level     (sw_level),
        .ev_valid     (valid0),
        .ev_ready     (ev_ready),
        .ev_idx       (idx0),
        .ev_level     (level0),
        .ev_pending   (pend0),
        .overflow_cnt (ovf0)
    );

    switch_event_scheduler #(.HOLDOFF(0), .CNT_W(2)) u_dut1 (
        .CLK50MHZ     (clk),
        .RST          (rst),
        .ev_in        (ev_in),
        .sw_level     (sw_level),
        .ev_valid     (valid1),
        .ev_ready     (ev_ready),
        .ev_idx       (idx1),
        .ev_level     (level1),
        .ev_pending   (pend1),
        .overflow_cnt (ovf1)
    );

    // Reference model: delivery timing is tracked as "earliest edge a grant may occur".
    bit [3:0] m_pend [2];
    bit [3:0] m_lvl [2];
    bit       m_off [2];
    int       m_idx [2];
    bit       m_level [2];
    int       m_ovf [2];
    int       m_last [2];
    int       m_earliest [2];
    int       ncyc = 0;

    function automatic int hold_of(input int m);
        return (m == 0) ? 2 : 0;
    endfunction

    function automatic int max_of(input int m);
        return (m == 0) ? 255 : 3;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]     = 4'b0;
            m_lvl[m]      = 4'b0;
            m_off[m]      = 1'b0;
            m_idx[m]      = 0;
            m_level[m]    = 1'b0;
            m_ovf[m]      = 0;
            m_last[m]     = 3;
            m_earliest[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input bit [3:0] ev, input bit [3:0] lv, input bit rdy);
        bit [3:0] clr;
        int       sel;
        clr = 4'b0;
        sel = 0;
        if (m_off[m] && rdy) begin
            m_off[m]      = 1'b0;
            m_earliest[m] = ncyc + hold_of(m) + 1;
        end else if (!m_off[m] && ncyc >= m_earliest[m] && m_pend[m] != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                sel = (m_last[m] + k) % 4;
                if (m_pend[m][sel]) break;
            end
            clr[sel]   = 1'b1;
            m_idx[m]   = sel;
            m_level[m] = m_lvl[m][sel];
            m_last[m]  = sel;
            m_off[m]   = 1'b1;
        end
        if ((ev & m_pend[m] & ~clr) != 4'b0 && m_ovf[m] < max_of(m)) m_ovf[m]++;
        m_pend[m] = (m_pend[m] & ~clr) | ev;
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) m_lvl[m][i] = lv[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".u0.valid"}, 32'(valid0), 32'(m_off[0]));
        chk({tag, ".u0.idx"},   32'(idx0),   32'(m_idx[0]));
        chk({tag, ".u0.level"}, 32'(level0), 32'(m_level[0]));
        chk({tag, ".u0.pend"},  32'(pend0),  32'(m_pend[0]));
        chk({tag, ".u0.ovf"},   32'(ovf0),   32'(m_ovf[0]));
        chk({tag, ".u1.valid"}, 32'(valid1), 32'(m_off[1]));
        chk({tag, ".u1.idx"},   32'(idx1),   32'(m_idx[1]));
        chk({tag, ".u1.level"}, 32'(level1), 32'(m_level[1]));
        chk({tag, ".u1.pend"},  32'(pend1),  32'(m_pend[1]));
        chk({tag, ".u1.ovf"},   32'(ovf1),   32'(m_ovf[1]));
    endtask

    // Called just after a falling edge: drive, clock, then check on the next falling edge.
    task automatic cycle(input string tag, input logic [3:0] ev, input logic [3:0] lv,
                         input logic rdy);
        ev_in    = ev;
        sw_level = lv;
        ev_ready = rdy;
        @(posedge clk);
        model_step(0, ev, lv, rdy);
        model_step(1, ev, lv, rdy);
        ncyc++;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        ev_in    = 4'b0;
        sw_level = 4'b0;
        ev_ready = 1'b0;
        rst      = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ev_in    = 4'b0;
        sw_level = 4'b0;
        ev_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single pulse on channel 2
        cycle("single", 4'b0100, 4'b0100, 1'b1);
        chk("single.valid_lat1", 32'(valid0), 32'd0);
        cycle("single", 4'b0000, 4'b0000, 1'b1);
        chk("single.valid_lat2", 32'(valid0), 32'd1);
        chk("single.idx", 32'(idx0), 32'd2);
        chk("single.level", 32'(level0), 32'd1);
        cycle("single", 4'b0000, 4'b0000, 1'b1);
        chk("single.drop", 32'(valid0), 32'd0);
        for (int i = 0; i < 4; i++) cycle("single", 4'b0000, 4'b0000, 1'b1);

        // All four channels at once, round-robin from channel 0
        do_reset();
        cycle("all4", 4'b1111, 4'b1010, 1'b1);
        for (int i = 0; i < 18; i++) cycle("all4", 4'b0000, 4'b0000, 1'b1);

        // Stalled consumer on channel 1, re-pulse during the offer
        do_reset();
        cycle("stall", 4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("stall", (i == 4) ? 4'b0010 : 4'b0000, 4'b0000, 1'b0);
        end
        chk("stall.ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 8; i++) cycle("stall", 4'b0000, 4'b0000, 1'b1);

        // Overflows on channel 3 while channel 0 is being offered
        do_reset();
        cycle("ovf", 4'b0001, 4'b0000, 1'b0);
        cycle("ovf", 4'b0000, 4'b0000, 1'b0);
        cycle("ovf", 4'b1000, 4'b1000, 1'b0);
        cycle("ovf", 4'b1000, 4'b0000, 1'b0);
        cycle("ovf", 4'b1000, 4'b1000, 1'b0);
        cycle("ovf", 4'b1000, 4'b0000, 1'b0);
        chk("ovf.three", 32'(ovf0), 32'd3);
        cycle("ovf", 4'b1000, 4'b1000, 1'b0);
        cycle("ovf", 4'b1000, 4'b1000, 1'b0);
        chk("ovf.five", 32'(ovf0), 32'd5);
        chk("ovf.sat", 32'(ovf1), 32'd3);
        for (int i = 0; i < 10; i++) cycle("ovf", 4'b0000, 4'b0000, 1'b1);

        // Capture on channel 0 in the very cycle it is granted
        do_reset();
        cycle("coll", 4'b0001, 4'b0001, 1'b0);
        cycle("coll", 4'b0001, 4'b0000, 1'b0);
        chk("coll.valid", 32'(valid0), 32'd1);
        chk("coll.level_old", 32'(level0), 32'd1);
        chk("coll.pend", 32'(pend0), 32'b0001);
        chk("coll.ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 8; i++) cycle("coll", 4'b0000, 4'b0000, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ev;
            ev = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            cycle("rand", ev, 4'($urandom), ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset while an event is being offered
        cycle("arst", 4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < 4; i++) cycle("arst", 4'b0000, 4'b0000, 1'b0);
        chk("arst.pre_valid", 32'(valid0), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst.u0.valid", 32'(valid0), 32'd0);
        chk("arst.u0.pend", 32'(pend0), 32'd0);
        chk("arst.u0.ovf", 32'(ovf0), 32'd0);
        chk("arst.u1.valid", 32'(valid1), 32'd0);
        chk("arst.u1.pend", 32'(pend1), 32'd0);
        chk("arst.u1.ovf", 32'(ovf1), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle("arst", 4'b1111, 4'b0101, 1'b1);
        cycle("arst", 4'b0000, 4'b0000, 1'b1);
        chk("arst.first_idx", 32'(idx0), 32'd0);
        chk("arst.first_level", 32'(level0), 32'd1);
        for (int i = 0; i < 14; i++) cycle("arst", 4'b0000, 4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
